// File: rtl/flow_mon_pkg.sv
// rtl/flow_mon_pkg.sv - shared types and sample classifier for the flow monitor
//
// Purpose: channel state / sample class enum and the classify helper used by
// every flow_mon_chan instance.
// Ports: none (package).
// Build option: FLOW_MON_STICKY_ALARM_EN (used by flow_mon_chan, not here).

package flow_mon_pkg;

  // One enum serves both as the debounced channel state and as the class of a
  // single sample; IDLE is only ever a state, never a sample class.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    OK   = 2'd2,
    HIGH = 2'd3
  } flow_state_e;

  // Callers zero-extend the W-bit sample, so the compare stays unsigned and
  // gives the same answer as a compare at width W.
  function automatic flow_state_e classify(input int unsigned flow,
                                           input int unsigned low_th,
                                           input int unsigned high_th);
    flow_state_e cls;
    if (flow < low_th) begin
      cls = LOW;
    end else if (flow > high_th) begin
      cls = HIGH;
    end else begin
      cls = OK;
    end
    return cls;
  endfunction

endpackage

// File: rtl/flow_mon_chan.sv
// rtl/flow_mon_chan.sv - one flow channel: classifier, debounce and alarm
//
// Purpose: classifies each valid sample, debounces class changes over
// DEBOUNCE consecutive qualifying samples and drives the channel alarm.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   sample_valid    - this cycle's sample is valid
//   flow [W-1:0]    - flow sample, L/min, unsigned
//   clr             - alarm clear request
//   low/in_range/high - registered one-hot debounced state (all 0 in IDLE)
//   alarm           - channel alarm
// Build option: FLOW_MON_STICKY_ALARM_EN selects the sticky alarm; otherwise
// alarm = low | high and clr is unused.

module flow_mon_chan
  import flow_mon_pkg::*;
#(
  parameter int unsigned W        = 6,
  parameter int unsigned LOW_TH   = 20,
  parameter int unsigned HIGH_TH  = 50,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] flow,
  input  logic         clr,
  output logic         low,
  output logic         in_range,
  output logic         high,
  output logic         alarm
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  flow_state_e   state_q, state_d;
  flow_state_e   cand_q, cand_d;
  flow_state_e   cls;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          low_q, low_d;
  logic          in_range_q, in_range_d;
  logic          high_q, high_d;

  // The counter never rests at CNT_MAX: reaching it commits the candidate and
  // clears it in the same cycle, so cnt_inc always fits in CW bits.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    cls     = classify(32'(flow), LOW_TH, HIGH_TH);
    cnt_inc = cnt_q + CNT_ONE;
    if (sample_valid) begin
      if (cls == state_q) begin
        cnt_d = '0;
      end else if (cls == cand_q) begin
        if (cnt_inc == CNT_MAX) begin
          state_d = cand_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cand_d = cls;
        // A fresh candidate already counts as one sample; with DEBOUNCE=1
        // that is enough to commit immediately.
        if (CNT_MAX == CNT_ONE) begin
          state_d = cls;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_ONE;
        end
      end
    end
    low_d      = (state_d == LOW);
    in_range_d = (state_d == OK);
    high_d     = (state_d == HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_q     <= OK;
      cnt_q      <= '0;
      low_q      <= 1'b0;
      in_range_q <= 1'b0;
      high_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      low_q      <= low_d;
      in_range_q <= in_range_d;
      high_q     <= high_d;
    end
  end

  assign low      = low_q;
  assign in_range = in_range_q;
  assign high     = high_q;

`ifdef FLOW_MON_STICKY_ALARM_EN
  logic alarm_q, alarm_d, alarm_set;

  // Set on entry into LOW/HIGH; clear only while currently OK. Set has
  // priority so an OK->LOW transition with clr held still raises the alarm.
  always_comb begin
    alarm_set = (state_d != state_q) && ((state_d == LOW) || (state_d == HIGH));
    alarm_d   = alarm_q;
    if (alarm_set) begin
      alarm_d = 1'b1;
    end else if (clr && (state_q == OK)) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign alarm      = low_q | high_q;
`endif

endmodule

// File: rtl/flow_monitor.sv
// rtl/flow_monitor.sv - NCH-channel debounced flow-rate monitor (top)
//
// Purpose: splits the packed flow bus into NCH lanes and runs one
// independent flow_mon_chan per lane.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_valid               - all channel samples valid this cycle
//   flow_rate [NCH*W-1:0]  - channel i at bits [i*W +: W]
//   alarm_clr [NCH-1:0]    - per-channel alarm clear request
//   low/in_range/high [NCH-1:0] - registered debounced channel state
//   alarm [NCH-1:0]        - per-channel alarm
// Build option: FLOW_MON_STICKY_ALARM_EN (sticky alarm, see flow_mon_chan).

module flow_monitor
  import flow_mon_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned W        = 6,
  parameter int unsigned LOW_TH   = 20,
  parameter int unsigned HIGH_TH  = 50,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [NCH*W-1:0] flow_rate,
  input  logic [NCH-1:0]   alarm_clr,
  output logic [NCH-1:0]   low,
  output logic [NCH-1:0]   in_range,
  output logic [NCH-1:0]   high,
  output logic [NCH-1:0]   alarm
);

  if ((LOW_TH > HIGH_TH) || (DEBOUNCE == 0) ||
      (64'(HIGH_TH) >= (64'd1 << W)) || (NCH == 0) || (NCH > 16)) begin : g_bad_params
    $error("flow_monitor: illegal parameter set");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    flow_mon_chan #(
      .W        (W),
      .LOW_TH   (LOW_TH),
      .HIGH_TH  (HIGH_TH),
      .DEBOUNCE (DEBOUNCE)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (in_valid),
      .flow         (flow_rate[i*W +: W]),
      .clr          (alarm_clr[i]),
      .low          (low[i]),
      .in_range     (in_range[i]),
      .high         (high[i]),
      .alarm        (alarm[i])
    );
  end

endmodule
